// File: rtl/keysched192_feeder_pkg.sv
// Shared types and sizing for the AES-192 key-schedule feeder and its word buffer.
package keysched192_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_GEN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int NUM_RK        = 13;
    localparam int NUM_GEN       = 8;
    localparam int WORDS_PER_GEN = 6;
    localparam int WORDS_PER_RK  = 4;
    localparam int BUF_WORDS     = 8;
    localparam int WORD_W        = 32;
    localparam int BUF_W         = BUF_WORDS * WORD_W;
    localparam int GEN_W         = WORDS_PER_GEN * WORD_W;
    localparam int RK_W          = WORDS_PER_RK * WORD_W;

endpackage

// File: rtl/keysched192_feeder_key_word_buffer.sv
// Eight-word ordered store: append six words behind the existing ones, pop the four oldest.
module key_word_buffer
    import keysched192_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push6_i,
    input  logic             pop4_i,
    input  logic [GEN_W-1:0] data6_i,
    output logic [RK_W-1:0]  data4_o,
    output logic [3:0]       count_o
);

    // Word 0 (oldest) sits in the top 32 bits, so popping is a left shift.
    logic [BUF_W-1:0] buf_q, buf_d, base_buf;
    logic [3:0]       count_q, count_d, base_cnt;
    logic [8:0]       shamt;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        base_buf = clear_i ? '0 : buf_q;
        base_cnt = clear_i ? '0 : count_q;
        shamt    = {base_cnt, 5'd0};
        buf_d    = base_buf;
        count_d  = base_cnt;
        if (pop4_i) begin
            buf_d   = base_buf << RK_W;
            count_d = base_cnt - 4'(WORDS_PER_RK);
        end else if (push6_i) begin
            buf_d   = base_buf | ({data6_i, {(BUF_W-GEN_W){1'b0}}} >> shamt);
            count_d = base_cnt + 4'(WORDS_PER_GEN);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the word store is explicitly cleared on reset, so no stale key material survives it.
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    assign data4_o = buf_q[BUF_W-1 -: RK_W];
    assign count_o = count_q;

endmodule

// File: rtl/keysched192_feeder.sv
// Sequencer between keysched192 and the round datapath: loads the key, paces generations
// and serves the 13 round keys of AES-192 one 128-bit key per request.
module keysched192_feeder
    import keysched192_feeder_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic [191:0]   key_i,
    input  logic           rk_req_i,
    output logic [127:0]   rk_o,
    output logic           rk_valid_o,
    output logic [3:0]     rk_idx_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           ks_start_o,
    output logic [3:0]     ks_round_o,
    output logic [191:0]   ks_last_key_o,
    input  logic [191:0]   ks_new_key_i,
    input  logic           ks_ready_i
);

    state_e         state_q;
    logic [3:0]     gen_cnt_q, rk_cnt_q;
    logic [127:0]   rk_q;
    logic           rk_valid_q, busy_q, done_q, ks_start_q;
    logic [3:0]     rk_idx_q, ks_round_q;
    logic [191:0]   ks_last_key_q;

    logic           load_ok, gen_ready, finished, serve, start_gen;
    logic [127:0]   buf_data;
    logic [3:0]     buf_count;

    assign load_ok   = load_i && (state_q == ST_IDLE || state_q == ST_DONE);
    assign gen_ready = (state_q == ST_GEN) && ks_ready_i;
    assign finished  = (state_q == ST_FILL) && (rk_cnt_q == 4'(NUM_RK));
    assign serve     = (state_q == ST_FILL) && (rk_cnt_q < 4'(NUM_RK)) && rk_req_i
                       && (buf_count >= 4'(WORDS_PER_RK));
    // A pending request with too few words is simply held; generation refills first.
    assign start_gen = (state_q == ST_FILL) && (rk_cnt_q < 4'(NUM_RK))
                       && (buf_count < 4'(WORDS_PER_RK)) && (gen_cnt_q < 4'(NUM_GEN));

    key_word_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .clear_i (load_ok || finished),
        .push6_i (load_ok || gen_ready),
        .pop4_i  (serve),
        .data6_i (load_ok ? key_i : ks_new_key_i),
        .data4_o (buf_data),
        .count_o (buf_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            gen_cnt_q     <= '0;
            rk_cnt_q      <= '0;
            rk_q          <= '0;
            rk_valid_q    <= 1'b0;
            rk_idx_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ks_start_q    <= 1'b0;
            ks_round_q    <= '0;
            ks_last_key_q <= '0;
        end else begin
            rk_valid_q <= 1'b0;
            ks_start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (load_ok) begin
                        ks_last_key_q <= key_i;
                        gen_cnt_q     <= '0;
                        rk_cnt_q      <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        state_q       <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (finished) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (serve) begin
                        rk_q       <= buf_data;
                        rk_valid_q <= 1'b1;
                        rk_idx_q   <= rk_cnt_q;
                        rk_cnt_q   <= rk_cnt_q + 4'd1;
                    end else if (start_gen) begin
                        gen_cnt_q  <= gen_cnt_q + 4'd1;
                        ks_round_q <= gen_cnt_q + 4'd1;
                        ks_start_q <= 1'b1;
                        state_q    <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    // keysched192 reads ks_last_key_o throughout, so it only moves on ready.
                    if (ks_ready_i) begin
                        ks_last_key_q <= ks_new_key_i;
                        state_q       <= ST_FILL;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rk_o          = rk_q;
    assign rk_valid_o    = rk_valid_q;
    assign rk_idx_o      = rk_idx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign ks_start_o    = ks_start_q;
    assign ks_round_o    = ks_round_q;
    assign ks_last_key_o = ks_last_key_q;

endmodule
